// File: rtl/rv32_pkg.sv
// Shared RV32 M-extension definitions: operand width, funct3 opcode encodings,
// sequencer state encoding and small opcode-decode helpers.
package rv32_pkg;

   localparam int XLEN = 32;

   // funct3 encodings of the M-extension R-type instructions
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } mul_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } muldiv_state_e;

   // Divide/remainder family (funct3[2] set)
   function automatic logic op_is_div(input mul_op_e op);
      return op[2];
   endfunction

   // Signed divide family: DIV and REM
   function automatic logic op_is_signed_div(input mul_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   // Remainder results: REM and REMU
   function automatic logic op_wants_rem(input mul_op_e op);
      return op[2] & op[1];
   endfunction

   // Multiplicand is signed for MUL, MULH, MULHSU
   function automatic logic op_sign_a(input mul_op_e op);
      return (op == MUL) || (op == MULH) || (op == MULHSU);
   endfunction

   // Multiplier is signed for MUL, MULH only
   function automatic logic op_sign_b(input mul_op_e op);
      return (op == MUL) || (op == MULH);
   endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per clock. Load captures the
// operands; XLEN iterations follow, Last flags the final one. Quotient and
// Remainder are valid the cycle after Last.
module div_iter
   import rv32_pkg::*;
#(
   parameter int XLEN = rv32_pkg::XLEN
) (
   input  logic            Clk,
   input  logic            Rst_N,
   input  logic            Load,
   input  logic [XLEN-1:0] Dividend,
   input  logic [XLEN-1:0] Divisor,
   output logic [XLEN-1:0] Quotient,
   output logic [XLEN-1:0] Remainder,
   output logic            Last
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] quo_r;
   logic [XLEN-1:0] rem_r;
   logic [XLEN-1:0] dvs_r;
   logic [CW-1:0]   cnt_r;
   logic            busy_r;
   logic [XLEN:0]   trial_s;
   logic [XLEN:0]   diff_s;
   logic [XLEN-1:0] quo_nxt_s;
   logic [XLEN-1:0] rem_nxt_s;

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      trial_s = {rem_r, quo_r[XLEN-1]};
      diff_s  = trial_s - {1'b0, dvs_r};
      if (diff_s[XLEN] == 1'b0) begin
         rem_nxt_s = diff_s[XLEN-1:0];
         quo_nxt_s = {quo_r[XLEN-2:0], 1'b1};
      end else begin
         rem_nxt_s = trial_s[XLEN-1:0];
         quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
      end
   end

   // Operand capture and iteration sequencing
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         quo_r  <= {XLEN{1'b0}};
         rem_r  <= {XLEN{1'b0}};
         dvs_r  <= {XLEN{1'b0}};
         cnt_r  <= {CW{1'b0}};
         busy_r <= 1'b0;
      end else if (Load) begin
         quo_r  <= Dividend;
         rem_r  <= {XLEN{1'b0}};
         dvs_r  <= Divisor;
         cnt_r  <= {CW{1'b0}};
         busy_r <= 1'b1;
      end else if (busy_r) begin
         quo_r <= quo_nxt_s;
         rem_r <= rem_nxt_s;
         cnt_r <= cnt_r + CW'(1);
         if (cnt_r == CW'(XLEN - 1)) begin
            busy_r <= 1'b0;
         end else begin
            busy_r <= 1'b1;
         end
      end else begin
         busy_r <= 1'b0;
      end
   end

   assign Quotient  = quo_r;
   assign Remainder = rem_r;
   assign Last      = busy_r && (cnt_r == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer: accepts an M-type instruction, runs a
// MUL_LAT-cycle multiply or an XLEN-step divide, stalls the pipeline while
// busy and returns a registered result with a one-cycle Done pulse.
module muldiv_seq
   import rv32_pkg::*;
#(
   parameter int XLEN    = rv32_pkg::XLEN,
   parameter int MUL_LAT = 2
) (
   input  logic            Clk,
   input  logic            Rst_N,
   input  logic            Start,
   input  logic [2:0]      MUL_Opcode,
   input  logic [XLEN-1:0] Operand_A,
   input  logic [XLEN-1:0] Operand_B,
   input  logic            Flush,
   output logic            Stall,
   output logic            Done,
   output logic [XLEN-1:0] Result
);

   localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam int              MCW  = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
   localparam bit              MUL_SINGLE = (MUL_LAT == 32'sd1);

   muldiv_state_e   state_r;
   mul_op_e         op_r;
   logic [XLEN-1:0] a_r;
   logic [XLEN-1:0] b_r;
   logic            neg_quo_r;
   logic            neg_rem_r;
   logic [MCW-1:0]  cnt_r;
   logic            done_r;
   logic [XLEN-1:0] result_r;

   mul_op_e           op_in_s;
   logic              div_signed_in_s;
   logic              div_zero_s;
   logic              div_ovf_s;
   logic              div_load_s;
   logic [XLEN-1:0]   a_mag_s;
   logic [XLEN-1:0]   b_mag_s;
   logic [XLEN-1:0]   special_res_s;
   mul_op_e           mul_op_s;
   logic [XLEN-1:0]   mul_a_s;
   logic [XLEN-1:0]   mul_b_s;
   logic [2*XLEN-1:0] mul_a_wide_s;
   logic [2*XLEN-1:0] mul_b_wide_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   mul_res_s;
   logic [XLEN-1:0]   div_quo_s;
   logic [XLEN-1:0]   div_rem_s;
   logic              div_last_s;
   logic [XLEN-1:0]   fix_res_s;
   logic              stall_s;

   assign op_in_s = mul_op_e'(MUL_Opcode);

   // Decode of the incoming instruction: special cases and divider operand magnitudes
   always_comb begin
      div_signed_in_s = op_is_signed_div(op_in_s);
      div_zero_s      = op_is_div(op_in_s) && (Operand_B == ZERO);
      div_ovf_s       = div_signed_in_s && (Operand_A == MIN) && (Operand_B == ONES);
      div_load_s      = (state_r == ST_IDLE) && Start && !Flush && op_is_div(op_in_s)
                        && !div_zero_s && !div_ovf_s;
      a_mag_s = (div_signed_in_s && Operand_A[XLEN-1]) ? (~Operand_A + ONE) : Operand_A;
      b_mag_s = (div_signed_in_s && Operand_B[XLEN-1]) ? (~Operand_B + ONE) : Operand_B;
      if (div_zero_s) begin
         special_res_s = op_wants_rem(op_in_s) ? Operand_A : ONES;
      end else begin
         special_res_s = op_wants_rem(op_in_s) ? ZERO : MIN;
      end
   end

   // Multiplier: operands sign/zero-extended to 2*XLEN so one unsigned product covers all variants
   always_comb begin
      if (state_r == ST_IDLE) begin
         mul_op_s = op_in_s;
         mul_a_s  = Operand_A;
         mul_b_s  = Operand_B;
      end else begin
         mul_op_s = op_r;
         mul_a_s  = a_r;
         mul_b_s  = b_r;
      end
      mul_a_wide_s = {{XLEN{op_sign_a(mul_op_s) & mul_a_s[XLEN-1]}}, mul_a_s};
      mul_b_wide_s = {{XLEN{op_sign_b(mul_op_s) & mul_b_s[XLEN-1]}}, mul_b_s};
      prod_s       = mul_a_wide_s * mul_b_wide_s;
      if (mul_op_s == MUL) begin
         mul_res_s = prod_s[XLEN-1:0];
      end else begin
         mul_res_s = prod_s[2*XLEN-1:XLEN];
      end
   end

   div_iter #(
      .XLEN (XLEN)
   ) u_div_iter (
      .Clk       (Clk),
      .Rst_N     (Rst_N),
      .Load      (div_load_s),
      .Dividend  (a_mag_s),
      .Divisor   (b_mag_s),
      .Quotient  (div_quo_s),
      .Remainder (div_rem_s),
      .Last      (div_last_s)
   );

   // Sign fix-up of the unsigned divider result
   always_comb begin
      if (op_wants_rem(op_r)) begin
         fix_res_s = neg_rem_r ? (~div_rem_s + ONE) : div_rem_s;
      end else begin
         fix_res_s = neg_quo_r ? (~div_quo_s + ONE) : div_quo_s;
      end
   end

   // Sequencer FSM with registered Done and Result
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state_r   <= ST_IDLE;
         op_r      <= MUL;
         a_r       <= ZERO;
         b_r       <= ZERO;
         neg_quo_r <= 1'b0;
         neg_rem_r <= 1'b0;
         cnt_r     <= {MCW{1'b0}};
         done_r    <= 1'b0;
         result_r  <= ZERO;
      end else if (Flush) begin
         state_r <= ST_IDLE;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  op_r      <= op_in_s;
                  a_r       <= Operand_A;
                  b_r       <= Operand_B;
                  neg_quo_r <= div_signed_in_s & (Operand_A[XLEN-1] ^ Operand_B[XLEN-1]);
                  neg_rem_r <= div_signed_in_s & Operand_A[XLEN-1];
                  cnt_r     <= {MCW{1'b0}};
                  if (div_zero_s || div_ovf_s) begin
                     result_r <= special_res_s;
                     done_r   <= 1'b1;
                     state_r  <= ST_DONE;
                  end else if (op_is_div(op_in_s)) begin
                     state_r <= ST_DIV;
                  end else if (MUL_SINGLE) begin
                     result_r <= mul_res_s;
                     done_r   <= 1'b1;
                     state_r  <= ST_DONE;
                  end else begin
                     state_r <= ST_MUL;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MUL: begin
               if (cnt_r == MCW'(MUL_LAT - 2)) begin
                  result_r <= mul_res_s;
                  done_r   <= 1'b1;
                  state_r  <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + MCW'(1);
               end
            end
            ST_DIV: begin
               if (div_last_s) begin
                  state_r <= ST_FIX;
               end else begin
                  state_r <= ST_DIV;
               end
            end
            ST_FIX: begin
               result_r <= fix_res_s;
               done_r   <= 1'b1;
               state_r  <= ST_DONE;
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Pipeline stall: combinational on Start only while idle, state decode otherwise
   always_comb begin
      stall_s = 1'b0;
      if (!Rst_N || Flush) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE:                stall_s = Start;
            ST_MUL, ST_DIV, ST_FIX: stall_s = 1'b1;
            default:                stall_s = 1'b0;
         endcase
      end
   end

   assign Stall  = stall_s;
   assign Done   = done_r;
   assign Result = result_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of reference-model results,
// latency/stall checks, flush and asynchronous-reset scenarios, random ops.
module tb_muldiv_seq;

   localparam int          MUL_LAT = 2;
   localparam logic [31:0] MINV    = 32'h8000_0000;
   localparam logic [31:0] ONESV   = 32'hFFFF_FFFF;
   localparam logic [2:0]  OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0]  OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic        Clk;
   logic        Rst_N;
   logic        Start;
   logic [2:0]  MUL_Opcode;
   logic [31:0] Operand_A;
   logic [31:0] Operand_B;
   logic        Flush;
   logic        Stall;
   logic        Done;
   logic [31:0] Result;

   int          n_compared;
   int          n_mismatched;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp;

   muldiv_seq #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
      .Clk        (Clk),
      .Rst_N      (Rst_N),
      .Start      (Start),
      .MUL_Opcode (MUL_Opcode),
      .Operand_A  (Operand_A),
      .Operand_B  (Operand_B),
      .Flush      (Flush),
      .Stall      (Stall),
      .Done       (Done),
      .Result     (Result)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Independent reference model in 64-bit integer arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MUL:    begin p = sa * sb;           return p[31:0];   end
         OP_MULH:   begin p = sa * sb;           return p[63:32];  end
         OP_MULHSU: begin p = sa * longint'(ub); return p[63:32];  end
         OP_MULHU:  begin up = ua * ub;          return up[63:32]; end
         OP_DIV: begin
            if (b == 32'd0) return ONESV;
            if (a == MINV && b == ONESV) return MINV;
            p = sa / sb;
            return p[31:0];
         end
         OP_REM: begin
            if (b == 32'd0) return a;
            if (a == MINV && b == ONESV) return 32'd0;
            p = sa % sb;
            return p[31:0];
         end
         OP_DIVU: begin
            if (b == 32'd0) return ONESV;
            up = ua / ub;
            return up[31:0];
         end
         OP_REMU: begin
            if (b == 32'd0) return a;
            up = ua % ub;
            return up[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op < OP_DIV) return MUL_LAT;
      if (b == 32'd0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == MINV && b == ONESV) return 1;
      return 34;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return ONESV;
         3:       return MINV;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Drive one instruction from an IDLE cycle (called at posedge+1), wait for Done, score it
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int          lat;
      int          stall_cnt;
      int          exp_lat;
      bit          got;
      logic [31:0] exp_res;
      exp_q.push_back(ref_model(op, a, b));
      exp_lat    = exp_latency(op, a, b);
      Start      = 1'b1;
      MUL_Opcode = op;
      Operand_A  = a;
      Operand_B  = b;
      lat        = 0;
      stall_cnt  = 0;
      got        = 1'b0;
      #1;
      while (!got && lat < 100) begin
         if (Stall) stall_cnt++;
         @(posedge Clk);
         #1;
         lat++;
         if (lat == 1) begin
            Operand_A  = ~a;
            Operand_B  = b ^ 32'h5A5A_0001;
            MUL_Opcode = op ^ 3'd1;
         end
         if (Done) got = 1'b1;
      end
      exp_res = exp_q.pop_front();
      if (!got) begin
         check({tag, "_timeout"}, 32'(lat), 32'(exp_lat));
      end else begin
         check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         check({tag, "_result"}, Result, exp_res);
         check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
         check({tag, "_stall_in_done"}, {31'd0, Stall}, 32'd0);
         last_exp = exp_res;
      end
      Start = 1'b0;
      @(posedge Clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
      check({tag, "_result_hold"}, Result, exp_res);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      n_compared   = 0;
      n_mismatched = 0;
      last_exp     = 32'd0;
      Rst_N        = 1'b0;
      Start        = 1'b0;
      Flush        = 1'b0;
      MUL_Opcode   = 3'd0;
      Operand_A    = 32'd0;
      Operand_B    = 32'd0;

      #12;
      check("reset_stall", {31'd0, Stall}, 32'd0);
      check("reset_done", {31'd0, Done}, 32'd0);
      check("reset_result", Result, 32'd0);
      @(negedge Clk);
      Rst_N = 1'b1;
      @(posedge Clk);
      #1;

      // Multiply family
      run_op(OP_MUL,    32'd7,  32'hFFFF_FFFD, "mul_7_m3");
      run_op(OP_MULH,   MINV,   MINV,          "mulh_min");
      run_op(OP_MULHSU, MINV,   MINV,          "mulhsu_min");
      run_op(OP_MULHU,  MINV,   MINV,          "mulhu_min");
      // Iterative divide
      run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,  "div_m7_2");
      run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,  "rem_m7_2");
      run_op(OP_DIVU,   32'd100, 32'd7,        "divu_100_7");
      run_op(OP_REMU,   32'd100, 32'd7,        "remu_100_7");
      // Special cases
      run_op(OP_DIV,    32'd1234, 32'd0,       "div_by0");
      run_op(OP_REMU,   32'd5,    32'd0,       "remu_by0");
      run_op(OP_DIV,    MINV,     ONESV,       "div_ovf");
      run_op(OP_REM,    MINV,     ONESV,       "rem_ovf");
      run_op(OP_DIV,    MINV,     32'd1,       "div_min_1");

      // Flush at iteration 10 of a divide
      Start      = 1'b1;
      MUL_Opcode = OP_DIV;
      Operand_A  = 32'd1000;
      Operand_B  = 32'd3;
      repeat (11) @(posedge Clk);
      #1;
      Flush = 1'b1;
      #1;
      check("flush_stall", {31'd0, Stall}, 32'd0);
      check("flush_done", {31'd0, Done}, 32'd0);
      @(posedge Clk);
      #1;
      Flush = 1'b0;
      Start = 1'b0;
      #1;
      check("post_flush_stall", {31'd0, Stall}, 32'd0);
      check("post_flush_done", {31'd0, Done}, 32'd0);
      check("post_flush_result", Result, last_exp);
      run_op(OP_DIVU, 32'd100, 32'd7, "div_after_flush");

      // Asynchronous reset in the middle of a divide
      Start      = 1'b1;
      MUL_Opcode = OP_DIV;
      Operand_A  = 32'd999;
      Operand_B  = 32'd9;
      repeat (6) @(posedge Clk);
      #3;
      Rst_N = 1'b0;
      #1;
      check("async_rst_stall", {31'd0, Stall}, 32'd0);
      check("async_rst_done", {31'd0, Done}, 32'd0);
      check("async_rst_result", Result, 32'd0);
      Start = 1'b0;
      @(negedge Clk);
      Rst_N = 1'b1;
      @(posedge Clk);
      #1;
      run_op(OP_MUL, 32'd3, 32'd4, "mul_after_rst");

      // Random regression with corner-biased operands
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick_operand();
         rb  = pick_operand();
         run_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
